// File: rtl/dct_transpose.sv
// 8x8 ping-pong transpose buffer between the row and column 1-D DCT passes.
// Words are written row-major into one bank and replayed column-major from the other.
module dct_transpose #(
  parameter int W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic signed [W-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic signed [W-1:0] out_data,
  output logic                out_last,
  input  logic                out_ready
);

  logic signed [W-1:0] mem [0:127];
  logic [5:0]          wr_cnt;
  logic [5:0]          rd_cnt;
  logic                wr_bank;
  logic                rd_bank;
  logic [1:0]          full;
  logic [1:0]          full_nxt;

  logic                wr_en_p0;
  logic                ld_p0;
  logic [6:0]          rd_addr_p0;

  assign in_ready   = !full[wr_bank];
  assign wr_en_p0   = in_valid && in_ready;
  assign ld_p0      = full[rd_bank] && (!out_valid || out_ready);
  // Bank in the MSB; row = rd_cnt%8, col = rd_cnt/8 gives the column-major walk.
  assign rd_addr_p0 = {rd_bank, rd_cnt[2:0], rd_cnt[5:3]};

  always_comb begin
    full_nxt = full;
    if (wr_en_p0 && (wr_cnt == 6'd63)) full_nxt[wr_bank] = 1'b1;
    if (ld_p0 && (rd_cnt == 6'd63))    full_nxt[rd_bank] = 1'b0;
  end

  // ---- stage 0: bank write ----
  always_ff @(posedge clk) begin
    if (wr_en_p0) mem[{wr_bank, wr_cnt}] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= 6'd0;
      wr_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      full <= full_nxt;
      if (wr_en_p0) begin
        wr_cnt <= wr_cnt + 6'd1;
        if (wr_cnt == 6'd63) wr_bank <= ~wr_bank;
      end
    end
  end

  // ---- stage 1: registered output ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt    <= 6'd0;
      rd_bank   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (ld_p0) begin
      out_data  <= mem[rd_addr_p0];
      out_valid <= 1'b1;
      out_last  <= (rd_cnt == 6'd63);
      rd_cnt    <= rd_cnt + 6'd1;
      if (rd_cnt == 6'd63) rd_bank <= ~rd_bank;
    end else if (out_ready && out_valid) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dct_transpose.sv
// Bench for dct_transpose: table-driven single-block checks plus streamed scoreboard scenarios.
module tb_dct_transpose;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_ready;

  always #5 clk = ~clk;

  dct_transpose #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         last;
  } vec_t;

  vec_t         tbl [64];
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] exp_q [$];
  bit           mon_en = 1'b0;
  bit           rdy_rand = 1'b0;
  int           mon_idx = 0;
  int           cyc = 0;
  int           first_t = 0;
  int           last_t = 0;
  int           stalls = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // kind 0: word n = n; kind 1: row 0 = -2048, row 7 = 2047, rest n
  task automatic fill_table(input int kind);
    for (int n = 0; n < 64; n++) begin
      if (kind == 1 && n < 8)        tbl[n].din = 12'h800;
      else if (kind == 1 && n >= 56) tbl[n].din = 12'h7FF;
      else                           tbl[n].din = W'(n);
    end
    for (int m = 0; m < 64; m++) begin
      tbl[m].dout = tbl[8 * (m % 8) + m / 8].din;
      tbl[m].last = (m == 63);
    end
  endtask

  task automatic run_table(input string tag);
    out_ready = 1'b1;
    for (int n = 0; n < 64; n++) begin
      in_valid = 1'b1;
      in_data  = tbl[n].din;
      @(negedge clk);
      if (n == 0 || n == 63) chk({tag, " in_ready"}, in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, " latency early"}, out_valid, 0);
    @(posedge clk); #1;
    for (int m = 0; m < 64; m++) begin
      @(negedge clk);
      chk({tag, " out_valid"}, out_valid, 1);
      chk({tag, " data"}, out_data, tbl[m].dout);
      chk({tag, " last"}, out_last, tbl[m].last);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tag, " idle after block"}, out_valid, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_block(input int base, input bit rnd, input int pval);
    logic [W-1:0] d [64];
    bit acc;
    int guard;
    for (int n = 0; n < 64; n++) d[n] = rnd ? W'($urandom) : W'(base + n);
    for (int m = 0; m < 64; m++) exp_q.push_back(d[8 * (m % 8) + m / 8]);
    for (int n = 0; n < 64; n++) begin
      acc = 1'b0;
      guard = 0;
      while (!acc) begin
        in_valid = ($urandom_range(1, 100) <= pval);
        in_data  = d[n];
        @(negedge clk);
        acc = in_valid && in_ready;
        if (in_valid && !in_ready) stalls++;
        @(posedge clk); #1;
        guard++;
        if (!acc && guard > 3000) begin
          chk("write timeout", 0, 1);
          acc = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain timeout", (guard >= 5000), 0);
    chk("drain leftover", exp_q.size(), 0);
  endtask

  task automatic monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected output", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("stream data", out_data, e);
        end
        chk("stream last", out_last, (mon_idx % 64 == 63));
        if (mon_idx == 0) first_t = cyc;
        last_t = cyc;
        mon_idx++;
      end
    end
  endtask

  task automatic rdy_gen();
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    fork
      monitor();
      rdy_gen();
      begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_last", out_last, 0);
    chk("reset out_data", out_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("in_ready after reset", in_ready, 1);
    @(posedge clk); #1;

    // single block, identity data
    fill_table(0);
    run_table("s1");

    // extreme values pass bit-exact
    fill_table(1);
    run_table("s4");

    // two back-to-back blocks without bubbles
    mon_en = 1'b1; mon_idx = 0; stalls = 0; out_ready = 1'b1;
    send_block(0, 1'b0, 100);
    send_block(100, 1'b0, 100);
    wait_drain();
    chk("s2 stalls", stalls, 0);
    chk("s2 output span", last_t - first_t, 127);

    // downstream blocked: both banks fill, then drain
    mon_idx = 0; stalls = 0; out_ready = 1'b0;
    send_block(0, 1'b0, 100);
    send_block(64, 1'b0, 100);
    chk("s3 stalls first two", stalls, 0);
    in_valid = 1'b1;
    in_data  = 12'hABC;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("s3 in_ready low", in_ready, 0);
      chk("s3 out_valid held", out_valid, 1);
      chk("s3 out_data held", out_data, 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send_block(128, 1'b0, 100);
    wait_drain();
    @(negedge clk);
    chk("s3 in_ready after drain", in_ready, 1);
    chk("s3 word count", mon_idx, 192);
    @(posedge clk); #1;

    // reset in mid-block discards the partial block
    mon_en = 1'b0;
    for (int n = 0; n < 30; n++) begin
      in_valid = 1'b1;
      in_data  = W'(n + 500);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("async reset out_data", out_data, 0);
    chk("async reset out_valid", out_valid, 0);
    chk("async reset in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_table(0);
    run_table("s5");

    // random handshake duty over 20 blocks
    mon_en = 1'b1; mon_idx = 0; rdy_rand = 1'b1;
    for (int b = 0; b < 20; b++) send_block(0, 1'b1, 50);
    wait_drain();
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    chk("s6 word count", mon_idx, 1280);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
